// File: rtl/tqvp_host_pkg.sv
// Shared types and command-byte field positions for the TinyQV byte-peripheral host.
package tqvp_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WSTROBE,
        RCAP,
        RRSP
    } state_e;

    localparam int unsigned CMD_DIR_BIT  = 7;
    localparam int unsigned CMD_LEN_MSB  = 6;
    localparam int unsigned CMD_LEN_LSB  = 4;
    localparam int unsigned CMD_ADDR_MSB = 3;

endpackage

// File: rtl/tqvp_byte_host.sv
// Byte-stream bus initiator: turns command/data bytes into byte-peripheral reads and writes.
// Every output is driven straight from a register.
module tqvp_byte_host
    import tqvp_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [3:0] periph_address,
    output logic       periph_data_write,
    output logic [7:0] periph_data_in,
    input  logic [7:0] periph_data_out
);

    state_e     r_state;
    logic [2:0] r_remaining;
    logic [3:0] r_address;
    logic [7:0] r_data_in;
    logic       r_write;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_busy;
    logic       r_cmd_ready;
    logic       w_cmd_hs;
    logic       w_rsp_hs;

    assign w_cmd_hs = cmd_valid & r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= 3'd0;
            r_address   <= 4'd0;
            r_data_in   <= 8'd0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_address   <= cmd_data[CMD_ADDR_MSB:0];
                        r_remaining <= cmd_data[CMD_LEN_MSB:CMD_LEN_LSB];
                        r_busy      <= 1'b1;
                        if (cmd_data[CMD_DIR_BIT]) begin
                            r_state <= WDATA;
                        end else begin
                            r_state     <= RCAP;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                WDATA: begin
                    // Bit 7 of a byte taken here is data; no command decode in this state.
                    if (w_cmd_hs) begin
                        r_data_in   <= cmd_data;
                        r_write     <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= WSTROBE;
                    end
                end
                WSTROBE: begin
                    r_write     <= 1'b0;
                    r_address   <= r_address + 4'd1;
                    r_cmd_ready <= 1'b1;
                    if (r_remaining == 3'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_remaining <= r_remaining - 3'd1;
                        r_state     <= WDATA;
                    end
                end
                RCAP: begin
                    // Address was registered last cycle, so data_out has settled.
                    r_rsp_data  <= periph_data_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RRSP;
                end
                RRSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_address   <= r_address + 4'd1;
                        if (r_remaining == 3'd0) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - 3'd1;
                            r_state     <= RCAP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready         = r_cmd_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = r_rsp_data;
    assign busy              = r_busy;
    assign periph_address    = r_address;
    assign periph_data_write = r_write;
    assign periph_data_in    = r_data_in;

endmodule

// File: tb/tb_tqvp_byte_host.sv
// Scoreboard bench for tqvp_byte_host driving a 16-byte register-file peripheral.
module tb_tqvp_byte_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_ready = 1'b0;
    logic       cmd_ready, rsp_valid, busy, periph_data_write;
    logic [7:0] rsp_data, periph_data_in, periph_data_out;
    logic [3:0] periph_address;

    tqvp_byte_host dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .busy              (busy),
        .periph_address    (periph_address),
        .periph_data_write (periph_data_write),
        .periph_data_in    (periph_data_in),
        .periph_data_out   (periph_data_out)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] pmem [16];
    logic [7:0] model [16];
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_rsp [$];
    int          strobe_cyc [$];
    bit          rdy_force = 1'b0;
    logic        rdy_val = 1'b0;

    // Peripheral stand-in: plain register file, combinational read.
    always @(posedge clk) if (periph_data_write) pmem[periph_address] <= periph_data_in;
    assign periph_data_out = pmem[periph_address];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe and every response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (periph_data_write) begin
                strobe_cyc.push_back(cyc);
                if (exp_wr.size() == 0) chk("unexpected_strobe", {20'd0, periph_address, periph_data_in}, 32'hFFFF_FFFF);
                else chk("strobe_addr_data", {20'd0, periph_address, periph_data_in}, {20'd0, exp_wr.pop_front()});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", {24'd0, rsp_data}, 32'hFFFF_FFFF);
                else chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit junk);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (junk) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'($urandom);
            @(negedge clk);
            chk("ignored_ready_low", {31'd0, cmd_ready}, 32'd0);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wr_byte(input logic [3:0] a, input logic [7:0] d, input bit junk);
        exp_wr.push_back({a, d});
        model[a] = d;
        send(d, junk);
    endtask

    task automatic rd_cmd(input logic [3:0] a, input int len, input bit junk);
        for (int i = 0; i <= len; i++) exp_rsp.push_back(model[a + 4'(i)]);
        send({1'b0, 3'(len), a}, junk);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_wr.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, {28'd0, periph_address}, 32'd0);
        chk({tag, "_din"}, {24'd0, periph_data_in}, 32'd0);
        chk({tag, "_wr"}, {31'd0, periph_data_write}, 32'd0);
        chk({tag, "_rv"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rd"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] d0;
        logic [7:0] bd [4];
        for (int i = 0; i < 16; i++) begin
            pmem[i]  = 8'd0;
            model[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");

        // Single write then read back.
        send(8'h80, 1'b0);
        wr_byte(4'h0, 8'h5A, 1'b0);
        @(negedge clk);
        chk("single_strobe_hi", {31'd0, periph_data_write}, 32'd1);
        @(negedge clk);
        chk("single_strobe_lo", {31'd0, periph_data_write}, 32'd0);
        rd_cmd(4'h0, 0, 1'b0);
        wait_done();

        // Read latency at address 1 with ready held high.
        send(8'h81, 1'b0);
        wr_byte(4'h1, 8'h3C, 1'b0);
        wait_done();
        rdy_force = 1'b1;
        rdy_val   = 1'b1;
        rd_cmd(4'h1, 0, 1'b0);
        @(negedge clk);
        chk("rd_lat_n1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_lat_n2_data", {24'd0, rsp_data}, 32'h3C);
        wait_done();
        rdy_force = 1'b0;

        // Burst write with wrap E,F,0,1.
        bd = '{8'h11, 8'h22, 8'h33, 8'h44};
        strobe_cyc.delete();
        send(8'hBE, 1'b0);
        for (int i = 0; i < 4; i++) wr_byte(4'hE + 4'(i), bd[i], 1'b0);
        wait_done();
        chk("burst_strobes", strobe_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < strobe_cyc.size(); i++)
            chk("burst_spacing", strobe_cyc[i] - strobe_cyc[i-1], 32'd2);

        // Response backpressure on a 2-byte read at 0.
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        rd_cmd(4'h0, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        d0 = rsp_data;
        chk("bp_first_data", {24'd0, d0}, {24'd0, model[0]});
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data_held", {24'd0, rsp_data}, {24'd0, d0});
            chk("bp_addr_held", {28'd0, periph_address}, 32'd0);
            @(negedge clk);
        end
        rdy_val = 1'b1;
        wait_done();
        rdy_force = 1'b0;

        // Ignored cmd_valid pulses during WSTROBE and RCAP.
        send(8'h92, 1'b0);
        wr_byte(4'h2, 8'hC7, 1'b1);
        wr_byte(4'h3, 8'h81, 1'b1);
        wait_done();
        rd_cmd(4'h2, 1, 1'b1);
        wait_done();

        // Reset in the middle of an 8-byte write burst.
        send(8'hF0, 1'b0);
        for (int i = 0; i < 3; i++) wr_byte(4'(i), 8'($urandom), 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_pending", exp_wr.size(), 32'd0);
        rd_cmd(4'h0, 3, 1'b0);
        wait_done();

        // Randomized command mix.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] a;
            int         len;
            a   = 4'($urandom_range(0, 15));
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                send({1'b1, 3'(len), a}, 1'b0);
                for (int i = 0; i <= len; i++)
                    wr_byte(a + 4'(i), 8'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                rd_cmd(a, len, 1'($urandom_range(0, 1)));
            end
            wait_done();
        end

        chk("end_wr_queue", exp_wr.size(), 32'd0);
        chk("end_rsp_queue", exp_rsp.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
